mult_arbiter: RTL and testbench
===============================

# mult_arbiter

Two-client arbiter that shares one `mult` multiplier instance between two independent requesters, such as `cbrt` and a second iterative function unit. Each client sees a port identical in behaviour to `mult`'s own start/busy/result handshake. The arbiter latches each request, grants the shared multiplier round-robin, drives its start pulse, and returns the 2·WIDTH product to the owning client. It sits between the client units and the single `mult` instance at the same hierarchy level as `sum`.

## Interface
- WIDTH, 8, operand width; product is 2·WIDTH.
- clk_i  in  1  clock, all logic on rising edge.
- rst_i  in  1  synchronous, active-low reset.
- c0_a_bi, c0_b_bi  in  WIDTH each  client 0 operands, sampled on accepted start.
- c0_start_i  in  1  client 0 request pulse.
- c0_busy_o  out  1  client 0 request outstanding.
- c0_y_bo  out  2·WIDTH  client 0 last product, held.
- c1_a_bi, c1_b_bi, c1_start_i, c1_busy_o, c1_y_bo: same as client 0, for client 1.
- mul_a, mul_b  out  WIDTH each  operands to the shared `mult`.
- mul_start_i  out  1  start pulse to the shared `mult`.
- mul_busy_o  in  1  busy from the shared `mult`.
- mul_y_bo  in  2·WIDTH  product from the shared `mult`.

## Operation
- Shared `mult` contract:
  - Samples a/b on an edge where start=1 and busy=0.
  - busy=1 from the next cycle until the product is ready.
  - y is valid and held from the cycle busy returns to 0.
- Per-client slot: {pending, a, b, y}.
  - cN_start_i=1 with pending=0: capture operands and set pending.
  - cN_start_i while pending=1: ignored. Operands and result are unchanged.
  - cN_busy_o equals pending.
- Priority register `prio` (reset 0) names the client that wins a tie.
  - After each grant, prio is set to the other client.
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
  - IDLE → ISSUE when any pending. grant = prio if that client is pending, else the one pending client. Toggle prio.
  - ISSUE: mul_start_i=1 for exactly this cycle, mul_a/mul_b = granted slot operands → WAIT_BUSY.
  - WAIT_BUSY: → WAIT_DONE on mul_busy_o=1.
  - WAIT_DONE: on mul_busy_o=0, write mul_y_bo into the granted slot's y, clear its pending → IDLE.
- mul_a/mul_b hold the granted operands from ISSUE through WAIT_DONE. They are 0 in IDLE.
- A client may re-request in the cycle after its busy drops. Its new request competes under the updated prio.
- Simultaneous starts are both captured in the same cycle. The grant follows prio.
- Reset (rst_i=0) has the following effect:
  - Applies in any state, including mid-multiply.
  - Clears all pending, y, prio and the operand regs. The FSM returns to IDLE.
  - The in-flight product is discarded.
  - The shared `mult` is reset in the same cycle by the integrating level.

## Timing
- Reset values: c0/c1_busy_o=0, c0/c1_y_bo=0, mul_start_i=0, mul_a=mul_b=0.
- All outputs are registered.
- Request accepted at edge k: cN_busy_o=1 after edge k.
- From IDLE with no contention:
  - ISSUE after edge k+1, so mul_start_i is high between edges k+1 and k+2.
  - WAIT_BUSY after k+2.
  - mult busy rises after k+2.
- Result written at the edge where WAIT_DONE sees mul_busy_o=0. cN_y_bo updates and cN_busy_o falls after that same edge.
- Arbiter overhead is 3 cycles per transaction beyond `mult` latency. There is no pipelining; one multiply is in flight at most.
- Worst-case wait for a client is one full transaction of the other client.

## Structure
- Package `mult_arb_pkg`: FSM state enum, client-index typedef (1 bit), default WIDTH.
- One sub-module `mult_req_slot`, instantiated twice. It holds the pending/operand/result registers and the start-accept logic.
- FSM, prio and the output mux live in `mult_arbiter`.

## Test plan
- Reset, c0 request 7×9, c1 idle → c0_y_bo=63, c0_busy_o drops, c1_y_bo stays 0, exactly one mul_start_i pulse.
- c0 12×12 and c1 255×255 in the same cycle after reset → c0 served first (144), then c1 (65025). Two start pulses, no overlap.
- c0 re-requests 3×5 in the cycle after its busy drops while c1 is pending → c1 completes before c0 (round-robin). c0_y_bo=15 after.
- c1 start 2×2 while c1_busy_o=1 for 4×4 → c1_y_bo=16. The second start is ignored and produces no extra mul_start_i.
- rst_i=0 for one cycle in WAIT_DONE of c0 100×3 → all outputs return to 0. A following c0 request 0×200 → c0_y_bo=0.
- Boundary operands 255×1 on c1 and 1×255 on c0 back-to-back → both give 255, and mul_a/mul_b match the granted slot during ISSUE.

Source files
------------

// File: rtl/mult_arb_pkg.sv
// rtl/mult_arb_pkg.sv - shared types and defaults for the two-client multiplier arbiter
//
// Contents:
//   DEFAULT_WIDTH : default operand width (product is 2*WIDTH)
//   arb_state_t   : arbiter FSM states
//   client_t      : client index, 0 or 1
package mult_arb_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_BUSY,
    ST_WAIT_DONE
  } arb_state_t;

  typedef logic client_t;

endpackage

// File: rtl/mult_req_slot.sv
// rtl/mult_req_slot.sv - per-client request slot: pending flag, latched operands, held result
//
// Ports:
//   clk_i, rst_i : clock, synchronous active-low reset
//   start        : client request pulse, accepted only while not pending
//   a, b         : client operands, captured on an accepted start
//   done         : arbiter strobe, writes y_in into the result and clears pending
//   y_in         : product from the shared multiplier
//   pending      : request outstanding (drives the client busy)
//   a_q, b_q     : latched operands
//   y_q          : last product, held until the next completion or reset
module mult_req_slot
  import mult_arb_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               done,
  input  logic [2*WIDTH-1:0] y_in,
  output logic               pending,
  output logic [WIDTH-1:0]   a_q,
  output logic [WIDTH-1:0]   b_q,
  output logic [2*WIDTH-1:0] y_q
);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      pending <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      y_q     <= '0;
    end else if (start && !pending) begin
      pending <= 1'b1;
      a_q     <= a;
      b_q     <= b;
    end else if (done) begin
      // done is only raised for a pending slot, so a start that arrives in
      // the same cycle is ignored by the branch above
      pending <= 1'b0;
      y_q     <= y_in;
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// rtl/mult_arbiter.sv - round-robin arbiter sharing one mult instance between two clients
//
// Ports:
//   clk_i, rst_i                 : clock, synchronous active-low reset
//   c0_a_bi, c0_b_bi, c0_start_i : client 0 operands and request pulse
//   c0_busy_o, c0_y_bo           : client 0 request outstanding, last product
//   c1_*                         : same for client 1
//   mul_a, mul_b, mul_start_i    : operands and start pulse to the shared mult
//   mul_busy_o, mul_y_bo         : busy and product from the shared mult
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [WIDTH-1:0]   c0_a_bi,
  input  logic [WIDTH-1:0]   c0_b_bi,
  input  logic               c0_start_i,
  output logic               c0_busy_o,
  output logic [2*WIDTH-1:0] c0_y_bo,
  input  logic [WIDTH-1:0]   c1_a_bi,
  input  logic [WIDTH-1:0]   c1_b_bi,
  input  logic               c1_start_i,
  output logic               c1_busy_o,
  output logic [2*WIDTH-1:0] c1_y_bo,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  output logic               mul_start_i,
  input  logic               mul_busy_o,
  input  logic [2*WIDTH-1:0] mul_y_bo
);

  arb_state_t       state, state_next;
  client_t          grant, grant_next;
  client_t          prio, prio_next;
  logic             done0, done1;
  logic [WIDTH-1:0] s0_a, s0_b, s1_a, s1_b;
  logic [WIDTH-1:0] a_next, b_next;

  mult_req_slot #(.WIDTH(WIDTH)) u_slot0 (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start   (c0_start_i),
    .a       (c0_a_bi),
    .b       (c0_b_bi),
    .done    (done0),
    .y_in    (mul_y_bo),
    .pending (c0_busy_o),
    .a_q     (s0_a),
    .b_q     (s0_b),
    .y_q     (c0_y_bo)
  );

  mult_req_slot #(.WIDTH(WIDTH)) u_slot1 (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start   (c1_start_i),
    .a       (c1_a_bi),
    .b       (c1_b_bi),
    .done    (done1),
    .y_in    (mul_y_bo),
    .pending (c1_busy_o),
    .a_q     (s1_a),
    .b_q     (s1_b),
    .y_q     (c1_y_bo)
  );

  always_comb begin
    state_next = state;
    grant_next = grant;
    prio_next  = prio;
    a_next     = mul_a;
    b_next     = mul_b;
    done0      = 1'b0;
    done1      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (c0_busy_o || c1_busy_o) begin
          state_next = ST_ISSUE;
          // prio wins when it has a request; otherwise the other client
          // must be the one pending
          grant_next = (prio ? c1_busy_o : c0_busy_o) ? prio : ~prio;
          prio_next  = ~grant_next;
          a_next     = grant_next ? s1_a : s0_a;
          b_next     = grant_next ? s1_b : s0_b;
        end
      end
      ST_ISSUE: begin
        state_next = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (mul_busy_o) begin
          state_next = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (!mul_busy_o) begin
          state_next = ST_IDLE;
          done0      = (grant == 1'b0);
          done1      = (grant == 1'b1);
          a_next     = '0;
          b_next     = '0;
        end
      end
      default: begin
        state_next = ST_IDLE;
        a_next     = '0;
        b_next     = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state       <= ST_IDLE;
      grant       <= 1'b0;
      prio        <= 1'b0;
      mul_a       <= '0;
      mul_b       <= '0;
      mul_start_i <= 1'b0;
    end else begin
      state       <= state_next;
      grant       <= grant_next;
      prio        <= prio_next;
      mul_a       <= a_next;
      mul_b       <= b_next;
      // registered copy of "in ISSUE" so the pulse is exactly one cycle
      mul_start_i <= (state_next == ST_ISSUE);
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// tb/tb_mult_arbiter.sv - directed self-checking bench for mult_arbiter with a behavioural mult
module tb_mult_arbiter;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic [7:0]  c0_a_bi = '0, c0_b_bi = '0, c1_a_bi = '0, c1_b_bi = '0;
  logic        c0_start_i = 1'b0, c1_start_i = 1'b0;
  logic        c0_busy_o, c1_busy_o;
  logic [15:0] c0_y_bo, c1_y_bo;
  logic [7:0]  mul_a, mul_b;
  logic        mul_start_i;
  logic        mul_busy_o;
  logic [15:0] mul_y_bo;

  int checks = 0;
  int errors = 0;

  mult_arbiter #(.WIDTH(8)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .c0_a_bi     (c0_a_bi),
    .c0_b_bi     (c0_b_bi),
    .c0_start_i  (c0_start_i),
    .c0_busy_o   (c0_busy_o),
    .c0_y_bo     (c0_y_bo),
    .c1_a_bi     (c1_a_bi),
    .c1_b_bi     (c1_b_bi),
    .c1_start_i  (c1_start_i),
    .c1_busy_o   (c1_busy_o),
    .c1_y_bo     (c1_y_bo),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_start_i (mul_start_i),
    .mul_busy_o  (mul_busy_o),
    .mul_y_bo    (mul_y_bo)
  );

  always #5 clk = ~clk;

  // Behavioural shared mult: busy for three cycles after an accepted start,
  // product valid and held once busy falls. Reset together with the arbiter.
  logic [7:0] m_a, m_b;
  logic [1:0] m_cnt;
  int         start_cnt = 0;
  int         overlap_cnt = 0;

  always @(posedge clk) begin
    if (mul_start_i) start_cnt++;
    if (mul_start_i && mul_busy_o) overlap_cnt++;
    if (!rst_i) begin
      mul_busy_o <= 1'b0;
      mul_y_bo   <= '0;
      m_cnt      <= '0;
      m_a        <= '0;
      m_b        <= '0;
    end else if (mul_busy_o) begin
      if (m_cnt == 2'd0) begin
        mul_busy_o <= 1'b0;
        mul_y_bo   <= 16'(m_a) * 16'(m_b);
      end else begin
        m_cnt <= m_cnt - 2'd1;
      end
    end else if (mul_start_i) begin
      m_a        <= mul_a;
      m_b        <= mul_b;
      mul_busy_o <= 1'b1;
      m_cnt      <= 2'd2;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_i = 1'b0;
    c0_start_i = 1'b0;
    c1_start_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_i = 1'b1;
  endtask

  task automatic req0(input logic [7:0] a, input logic [7:0] b);
    c0_a_bi = a; c0_b_bi = b; c0_start_i = 1'b1;
    @(negedge clk);
    c0_start_i = 1'b0;
  endtask

  task automatic req1(input logic [7:0] a, input logic [7:0] b);
    c1_a_bi = a; c1_b_bi = b; c1_start_i = 1'b1;
    @(negedge clk);
    c1_start_i = 1'b0;
  endtask

  task automatic wait_idle(input int which, input string tag);
    int n = 0;
    while (((which == 0) ? c0_busy_o : c1_busy_o) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL %s timeout: c%0d_busy_o still 1 after %0d cycles, need 0", tag, which, n);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({c0_busy_o, c1_busy_o, mul_start_i} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got busy0=%b busy1=%b start=%b need 0 0 0", c0_busy_o, c1_busy_o, mul_start_i);
    end
    checks++;
    if ({c0_y_bo, c1_y_bo, mul_a, mul_b} !== 48'd0) begin
      errors++;
      $display("FAIL reset_data got y0=%0d y1=%0d a=%0d b=%0d need all 0", c0_y_bo, c1_y_bo, mul_a, mul_b);
    end
  endtask

  task automatic test_single();
    int s0;
    s0 = start_cnt;
    req0(8'd7, 8'd9);
    checks++;
    if (c0_busy_o !== 1'b1 || mul_start_i !== 1'b0) begin
      errors++;
      $display("FAIL single_accept got busy0=%b start=%b need 1 0", c0_busy_o, mul_start_i);
    end
    @(negedge clk);
    checks++;
    if (mul_start_i !== 1'b1 || mul_a !== 8'd7 || mul_b !== 8'd9) begin
      errors++;
      $display("FAIL single_issue got start=%b a=%0d b=%0d need 1 7 9", mul_start_i, mul_a, mul_b);
    end
    @(negedge clk);
    checks++;
    if (mul_start_i !== 1'b0 || mul_a !== 8'd7) begin
      errors++;
      $display("FAIL single_hold got start=%b a=%0d need 0 7", mul_start_i, mul_a);
    end
    wait_idle(0, "single_wait");
    checks++;
    if (c0_y_bo !== 16'd63 || c1_y_bo !== 16'd0) begin
      errors++;
      $display("FAIL single_y got y0=%0d y1=%0d need 63 0", c0_y_bo, c1_y_bo);
    end
    checks++;
    if (mul_a !== 8'd0 || mul_b !== 8'd0) begin
      errors++;
      $display("FAIL single_idle_ops got a=%0d b=%0d need 0 0", mul_a, mul_b);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (start_cnt - s0 !== 1) begin
      errors++;
      $display("FAIL single_pulses got %0d need 1", start_cnt - s0);
    end
  endtask

  task automatic test_simultaneous();
    int s0, n;
    do_reset();
    s0 = start_cnt;
    c0_a_bi = 8'd12; c0_b_bi = 8'd12; c0_start_i = 1'b1;
    c1_a_bi = 8'd255; c1_b_bi = 8'd255; c1_start_i = 1'b1;
    @(negedge clk);
    c0_start_i = 1'b0; c1_start_i = 1'b0;
    checks++;
    if (c0_busy_o !== 1'b1 || c1_busy_o !== 1'b1) begin
      errors++;
      $display("FAIL simul_capture got busy0=%b busy1=%b need 1 1", c0_busy_o, c1_busy_o);
    end
    n = 0;
    while (c0_busy_o && c1_busy_o && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (c0_busy_o !== 1'b0 || c1_busy_o !== 1'b1 || c0_y_bo !== 16'd144) begin
      errors++;
      $display("FAIL simul_first got busy0=%b busy1=%b y0=%0d need 0 1 144", c0_busy_o, c1_busy_o, c0_y_bo);
    end
    wait_idle(1, "simul_wait1");
    checks++;
    if (c1_y_bo !== 16'd65025) begin
      errors++;
      $display("FAIL simul_y1 got %0d need 65025", c1_y_bo);
    end
    checks++;
    if (start_cnt - s0 !== 2 || overlap_cnt !== 0) begin
      errors++;
      $display("FAIL simul_pulses got pulses=%0d overlaps=%0d need 2 0", start_cnt - s0, overlap_cnt);
    end
  endtask

  task automatic test_round_robin();
    int n;
    c0_a_bi = 8'd2; c0_b_bi = 8'd3; c0_start_i = 1'b1;
    c1_a_bi = 8'd6; c1_b_bi = 8'd7; c1_start_i = 1'b1;
    @(negedge clk);
    c0_start_i = 1'b0; c1_start_i = 1'b0;
    wait_idle(0, "rr_wait0");
    checks++;
    if (c0_y_bo !== 16'd6 || c1_busy_o !== 1'b1) begin
      errors++;
      $display("FAIL rr_first got y0=%0d busy1=%b need 6 1", c0_y_bo, c1_busy_o);
    end
    req0(8'd3, 8'd5);
    n = 0;
    while (c0_busy_o && c1_busy_o && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (c1_busy_o !== 1'b0 || c0_busy_o !== 1'b1 || c1_y_bo !== 16'd42) begin
      errors++;
      $display("FAIL rr_order got busy0=%b busy1=%b y1=%0d need 1 0 42", c0_busy_o, c1_busy_o, c1_y_bo);
    end
    wait_idle(0, "rr_wait0b");
    checks++;
    if (c0_y_bo !== 16'd15) begin
      errors++;
      $display("FAIL rr_y0 got %0d need 15", c0_y_bo);
    end
  endtask

  task automatic test_ignore_busy();
    int s0;
    s0 = start_cnt;
    req1(8'd4, 8'd4);
    req1(8'd2, 8'd2);
    wait_idle(1, "ignore_wait");
    repeat (4) @(negedge clk);
    checks++;
    if (c1_y_bo !== 16'd16 || c1_busy_o !== 1'b0) begin
      errors++;
      $display("FAIL ignore_y1 got y1=%0d busy1=%b need 16 0", c1_y_bo, c1_busy_o);
    end
    checks++;
    if (start_cnt - s0 !== 1) begin
      errors++;
      $display("FAIL ignore_pulses got %0d need 1", start_cnt - s0);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    req0(8'd100, 8'd3);
    n = 0;
    while (!mul_busy_o && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL midrst_busy timeout mul busy got 0 need 1");
    end
    @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b1;
    checks++;
    if ({c0_busy_o, c1_busy_o, mul_start_i} !== 3'b000 || {c0_y_bo, c1_y_bo, mul_a, mul_b} !== 48'd0) begin
      errors++;
      $display("FAIL midrst_clear got busy0=%b busy1=%b start=%b y0=%0d y1=%0d a=%0d b=%0d need all 0",
               c0_busy_o, c1_busy_o, mul_start_i, c0_y_bo, c1_y_bo, mul_a, mul_b);
    end
    repeat (6) @(negedge clk);
    checks++;
    if (c0_y_bo !== 16'd0 || c0_busy_o !== 1'b0) begin
      errors++;
      $display("FAIL midrst_stale got y0=%0d busy0=%b need 0 0", c0_y_bo, c0_busy_o);
    end
    req0(8'd0, 8'd200);
    checks++;
    if (c0_busy_o !== 1'b1) begin
      errors++;
      $display("FAIL midrst_accept got busy0=%b need 1", c0_busy_o);
    end
    wait_idle(0, "midrst_wait");
    checks++;
    if (c0_y_bo !== 16'd0) begin
      errors++;
      $display("FAIL midrst_zero got y0=%0d need 0", c0_y_bo);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] sa [2];
    logic [7:0] sb [2];
    int idx = 0;
    int n = 0;
    sa[0] = '0; sa[1] = '0; sb[0] = '0; sb[1] = '0;
    req1(8'd255, 8'd1);
    req0(8'd1, 8'd255);
    while (n < 100 && !(idx >= 2 && !c0_busy_o && !c1_busy_o)) begin
      if (mul_start_i && idx < 2) begin
        sa[idx] = mul_a;
        sb[idx] = mul_b;
        idx++;
      end
      @(negedge clk);
      n++;
    end
    checks++;
    if (idx !== 2) begin
      errors++;
      $display("FAIL b2b_pulses got %0d need 2", idx);
    end
    checks++;
    if (sa[0] !== 8'd255 || sb[0] !== 8'd1) begin
      errors++;
      $display("FAIL b2b_issue1 got a=%0d b=%0d need 255 1", sa[0], sb[0]);
    end
    checks++;
    if (sa[1] !== 8'd1 || sb[1] !== 8'd255) begin
      errors++;
      $display("FAIL b2b_issue2 got a=%0d b=%0d need 1 255", sa[1], sb[1]);
    end
    checks++;
    if (c0_y_bo !== 16'd255 || c1_y_bo !== 16'd255) begin
      errors++;
      $display("FAIL b2b_y got y0=%0d y1=%0d need 255 255", c0_y_bo, c1_y_bo);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_round_robin();
    test_ignore_busy();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (overlap_cnt !== 0) begin
      errors++;
      $display("FAIL overlap got %0d start pulses while mult busy need 0", overlap_cnt);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
